clock_divider_multi: RTL
========================

// Module: clock_divider_multi
// PURPOSE
//   Multi-channel programmable clock divider driven from the 1 MHz system clock.
//   Each of NUM_CH channels produces a divided clock-enable style square wave with a
//   run-time divide ratio, independent enable and glitch-free ratio changes at period
//   boundaries. Serves the deserialiser datapath, which needs 100 kHz / 10 kHz and other rates.
// PARAMETERS
//   NUM_CH     2    number of independent output channels (1..16)
//   DIV_W      16   width of divide ratio and per-channel counter
//   RESET_DIV  10   divide ratio loaded into every channel at reset (must be >= 2)
// PORTS
//   clock_1M   input   1                   1 MHz system clock, all logic on rising edge
//   reset      input   1                   asynchronous, active-low reset
//   enable     input   NUM_CH              per-channel run enable
//   div_wr     input   1                   one-cycle write strobe for a new ratio
//   div_sel    input   max(1,$clog2(NUM_CH)) target channel of div_wr
//   div_val    input   DIV_W               new divide ratio N
//   clock_out  output  NUM_CH              divided clocks, registered outputs
//   pending    output  NUM_CH              shadow ratio written but not yet active
//   div_err    output  1                   one-cycle pulse: rejected write
//   tick       output  NUM_CH              wrap pulses (only with TICK_OUT_EN)
// BEHAVIOUR
//   - Reset (reset=0, async): cnt=0, active N=shadow=RESET_DIV, clock_out=0, pending=0,
//     div_err=0, tick=0 on every channel. Same when reset is asserted mid-operation.
//   - Per channel while enable=1: cnt counts 0..N-1 and wraps to 0; period = N cycles.
//   - clock_out is a register. During a cycle where cnt holds value c, clock_out=1 iff c>=N/2
//     (integer division). There is no combinational path to clock_out.
//     Even N: 50 % duty. Odd N: low for (N-1)/2 cycles, high for (N+1)/2 cycles.
//     Example N=10: 5 cycles low, then 5 high.
//   - enable=0: cnt forced to 0 and clock_out=0 on the next edge. On the first enabled cycle,
//     cnt=0 and clock_out stays low for N/2 cycles.
//   - Writes: div_wr=1 with a valid div_sel and div_val>=2 loads shadow[div_sel] and sets
//     pending[div_sel] on the next edge.
//   - Rejected writes (div_val<2 or div_sel>=NUM_CH): no state change; div_err=1 for exactly
//     one cycle on the next edge.
//   - Applying a ratio: shadow is copied to active N on the edge where cnt wraps (cnt==N-1)
//     while enabled, or on the next edge if the channel is disabled. pending clears on that
//     same edge. The current period always completes with the old N; no runt or stretched
//     pulse.
//   - Simultaneous events:
//       * Write on the same edge as a wrap: the wrap uses the old shadow; the new value
//         stays pending until the next wrap.
//       * Second write before apply: it overwrites the shadow; only the last value is applied.
//   - Counter width: cnt is DIV_W bits. N up to 2^DIV_W-1 is supported, with no overflow.
//   - Channels are fully independent; writes to one channel never disturb the phase of another.
// CONFIGURATION
//   TICK_OUT_EN defined:
//     - tick[i]=1 for exactly one cycle, registered, on the edge where channel i wraps from
//       N-1 to 0. This is one pulse per period while enabled.
//     - tick[i]=0 while disabled or in reset.
//   TICK_OUT_EN undefined: tick port present but tied to 0; no tick logic is synthesised.
// TESTING
//   1 Reset release, enable=2'b11, defaults:
//       -> both clock_out low for 5 cycles, high for 5 cycles, period 10; pending=0.
//   2 Write ch1 div_val=100 mid-period:
//       -> pending[1]=1 until ch1 wraps; that period is still 10 cycles;
//       -> subsequent periods are 100 cycles, 50 high; ch0 phase unchanged.
//   3 Write div_val=1, then div_sel=3 with NUM_CH=2:
//       -> div_err pulses one cycle each time; shadow and pending unchanged.
//   4 Odd ratio N=7:
//       -> clock_out 3 cycles low, 4 high, repeating; with TICK_OUT_EN, tick every 7th cycle.
//   5 Drop enable[0] mid-period, then write N=4:
//       -> clock_out[0]=0 next edge, N applied next edge; re-enable gives 2 low / 2 high.
//   6 Assert reset mid-period with a write pending:
//       -> all outputs 0 immediately, N back to 10;
//       -> after release, both channels restart from cnt=0.

Source files
------------

// File: rtl/clock_divider_multi_if.sv
// Ratio-write bus for clock_divider_multi: write strobe, channel select, new ratio
// and the registered reject pulse returned by the divider.
interface clock_divider_multi_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [DIV_W-1:0] div_val;
  logic             div_err;

  modport master (output div_wr, div_sel, div_val, input div_err);
  modport slave  (input div_wr, div_sel, div_val, output div_err);
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with shadowed, period-aligned ratio updates.
// Optional macro TICK_OUT_EN adds a registered one-cycle wrap pulse per channel on tick.
module clock_divider_multi #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 10
) (
  input  logic                 clock_1M,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    enable,
  clock_divider_multi_if.slave bus,
  output logic [NUM_CH-1:0]    clock_out,
  output logic [NUM_CH-1:0]    pending,
  output logic [NUM_CH-1:0]    tick
);
  localparam int               SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] RST_N = DIV_W'(RESET_DIV);

  logic sel_ok;
  logic val_ok;
  logic wr_ok;

  assign sel_ok = (32'(bus.div_sel) < 32'(NUM_CH));
  assign val_ok = (bus.div_val >= DIV_W'(2));
  assign wr_ok  = bus.div_wr & sel_ok & val_ok;

  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset) begin
      bus.div_err <= 1'b0;
    end else begin
      bus.div_err <= bus.div_wr & ~(sel_ok & val_ok);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] n_q;
    logic [DIV_W-1:0] n_d;
    logic [DIV_W-1:0] shadow_q;
    logic             pend_q;
    logic             clk_q;
    logic             wrap;
    logic             wr_hit;
    logic             apply;

    assign wr_hit = wr_ok && (bus.div_sel == SEL_W'(i));
    assign wrap   = enable[i] && (cnt_q == n_q - DIV_W'(1));
    // A disabled channel has no period in flight, so the shadow may land at once.
    assign apply  = pend_q && (wrap || !enable[i]);

    always_comb begin
      cnt_d = '0;
      n_d   = n_q;
      if (enable[i] && !wrap) begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      if (apply) begin
        n_d = shadow_q;
      end
    end

    // clock_out is computed from the next count so the register tracks cnt cycle-for-cycle.
    always_ff @(posedge clock_1M or negedge reset) begin
      if (!reset) begin
        cnt_q    <= '0;
        n_q      <= RST_N;
        shadow_q <= RST_N;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        n_q   <= n_d;
        clk_q <= (cnt_d >= (n_d >> 1));
        if (wr_hit) begin
          shadow_q <= bus.div_val;
          pend_q   <= 1'b1;
        end else if (apply) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign clock_out[i] = clk_q;
    assign pending[i]   = pend_q;

`ifdef TICK_OUT_EN
    logic tick_q;

    always_ff @(posedge clock_1M or negedge reset) begin
      if (!reset) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= wrap;
      end
    end

    assign tick[i] = tick_q;
`else
    assign tick[i] = 1'b0;
`endif
  end
endmodule
